// File: rtl/imem_port_arbiter.sv
// Arbiter sharing a single-ported, fixed-latency instruction memory between
// the fetch unit and the loader/debug port; fetch has priority, loader is starvation-protected.
module imem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        fetch_en_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_flush_i,
  output logic        fetch_gnt_o,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  input  logic        ld_req_i,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        ld_gnt_o,
  output logic        ld_rvalid_o,
  output logic [31:0] ld_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_LD = 2'd2} owner_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic        flushed_q, flushed_d;

  logic        win, f_ok, ld_win, f_win, resp;

  // Handshake: a requester holds *_req_i until it sees *_gnt_o in the same
  // cycle; address/data are sampled only in that grant cycle. The matching
  // *_rvalid_o pulses exactly MEM_LAT cycles later and needs no ready.
  always_comb begin
    resp   = (state_q == BUSY) && (lat_q == 3'd0);
    win    = reset_ni && ((state_q == IDLE) || (lat_q == 3'd0));
    f_ok   = fetch_req_i & fetch_en_i & ~fetch_flush_i;
    ld_win = win & ld_req_i & (~f_ok | (starve_q == STARVE_LIM));
    f_win  = win & f_ok & ~ld_win;

    fetch_gnt_o    = f_win;
    ld_gnt_o       = ld_win;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = 32'd0;
    mem_wdata_o    = 32'd0;
    if (ld_win) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ld_we_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
    end else if (f_win) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = fetch_addr_i;
    end

    // A flush arriving in the response cycle itself still kills the data.
    fetch_rvalid_o = resp && (owner_q == OWN_FETCH) && !flushed_q && !fetch_flush_i;
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : 32'd0;
    ld_rvalid_o    = resp && (owner_q == OWN_LD);
    ld_rdata_o     = (ld_rvalid_o && !we_q) ? mem_rdata_i : 32'd0;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    we_d      = we_q;
    flushed_d = flushed_q;
    starve_d  = starve_q;

    if (resp) begin
      state_d   = IDLE;
      owner_d   = OWN_NONE;
      flushed_d = 1'b0;
      we_d      = 1'b0;
    end else if (state_q == BUSY) begin
      lat_d = lat_q - 3'd1;
      if (owner_q == OWN_FETCH && fetch_flush_i) flushed_d = 1'b1;
    end

    if (f_win || ld_win) begin
      state_d   = BUSY;
      lat_d     = LAT_INIT;
      owner_d   = ld_win ? OWN_LD : OWN_FETCH;
      we_d      = ld_win & ld_we_i;
      flushed_d = 1'b0;
    end

    if (!ld_req_i || ld_win) starve_d = 4'd0;
    else if (win && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      lat_q     <= 3'd0;
      we_q      <= 1'b0;
      flushed_q <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_q     <= lat_d;
      we_q      <= we_d;
      flushed_q <= flushed_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: one instance at MEM_LAT=2/STARVE_MAX=4,
// a second at MEM_LAT=1/STARVE_MAX=1 for back-to-back alternation.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 0: MEM_LAT=2, STARVE_MAX=4 ----------------
  logic        fetch_en_i = 1'b1, fetch_req_i = 1'b0, fetch_flush_i = 1'b0;
  logic [31:0] fetch_addr_i = 32'd0;
  logic        ld_req_i = 1'b0, ld_we_i = 1'b0;
  logic [31:0] ld_addr_i = 32'd0, ld_wdata_i = 32'd0;
  logic        fetch_gnt_o, fetch_rvalid_o, ld_gnt_o, ld_rvalid_o;
  logic [31:0] fetch_rdata_o, ld_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  imem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .fetch_en_i(fetch_en_i), .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_flush_i(fetch_flush_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
    .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Memory model: 256 words, read data appears two cycles after the strobe.
  logic [31:0] mem_m [256];
  logic [31:0] p1, p2;
  initial for (int i = 0; i < 256; i++) mem_m[i] = init_word(32'(i * 4));
  always @(posedge clk) begin
    if (mem_en_o) begin
      p1 <= mem_m[mem_addr_o[9:2]];
      if (mem_we_o) mem_m[mem_addr_o[9:2]] = mem_wdata_o;
    end else begin
      p1 <= 32'hBAD0_BAD0;
    end
    p2 <= p1;
  end
  assign mem_rdata_i = p2;

  // ---------------- instance 1: MEM_LAT=1, STARVE_MAX=1 ----------------
  logic        f1_req = 1'b0, l1_req = 1'b0;
  logic [31:0] f1_addr = 32'd0, l1_addr = 32'd0;
  logic        f1_gnt, f1_rv, l1_gnt, l1_rv, m1_en, m1_we;
  logic [31:0] f1_rd, l1_rd, m1_addr, m1_wdata, m1_rdata;

  imem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(1)) dut1 (
    .clk_i(clk), .reset_ni(rst_n),
    .fetch_en_i(1'b1), .fetch_req_i(f1_req), .fetch_addr_i(f1_addr),
    .fetch_flush_i(1'b0), .fetch_gnt_o(f1_gnt),
    .fetch_rvalid_o(f1_rv), .fetch_rdata_o(f1_rd),
    .ld_req_i(l1_req), .ld_we_i(1'b0), .ld_addr_i(l1_addr), .ld_wdata_i(32'd0),
    .ld_gnt_o(l1_gnt), .ld_rvalid_o(l1_rv), .ld_rdata_o(l1_rd),
    .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr),
    .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata)
  );

  always @(posedge clk) m1_rdata <= m1_en ? ~m1_addr : 32'hBAD1_BAD1;

  // ---------------- scoreboard ----------------
  logic [31:0] f_exp_q[$], l_exp_q[$], f1_exp_q[$], l1_exp_q[$];
  int          f_cyc_q[$], l_cyc_q[$], f1_cyc_q[$], l1_cyc_q[$];
  logic        glog[$];
  int          n_f_exp = 0, n_f_rv = 0, n_fgnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (fetch_gnt_o) begin glog.push_back(1'b0); n_fgnt++; end
    if (ld_gnt_o) glog.push_back(1'b1);
    if (fetch_rvalid_o) begin
      n_f_rv++;
      if (f_exp_q.size() == 0) chk("fetch_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("fetch_rdata", fetch_rdata_o, f_exp_q.pop_front());
        chk("fetch_rvalid_cycle", 32'(cyc), 32'(f_cyc_q.pop_front()));
      end
    end else if (fetch_rdata_o != 32'd0) chk("fetch_rdata_idle", fetch_rdata_o, 32'd0);
    if (ld_rvalid_o) begin
      if (l_exp_q.size() == 0) chk("ld_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("ld_rdata", ld_rdata_o, l_exp_q.pop_front());
        chk("ld_rvalid_cycle", 32'(cyc), 32'(l_cyc_q.pop_front()));
      end
    end else if (ld_rdata_o != 32'd0) chk("ld_rdata_idle", ld_rdata_o, 32'd0);
    if (f1_rv) begin
      if (f1_exp_q.size() == 0) chk("alt_fetch_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("alt_fetch_rdata", f1_rd, f1_exp_q.pop_front());
        chk("alt_fetch_rvalid_cycle", 32'(cyc), 32'(f1_cyc_q.pop_front()));
      end
    end
    if (l1_rv) begin
      if (l1_exp_q.size() == 0) chk("alt_ld_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        chk("alt_ld_rdata", l1_rd, l1_exp_q.pop_front());
        chk("alt_ld_rvalid_cycle", 32'(cyc), 32'(l1_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic f_issue(input logic [31:0] a, input bit exp_resp, output int gcyc);
    gcyc = -1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = a;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (fetch_gnt_o) begin gcyc = cyc; break; end
      @(posedge clk); #1;
    end
    if (gcyc < 0) chk("fetch_gnt_timeout", 32'd0, 32'd1);
    else if (exp_resp) begin
      f_exp_q.push_back(init_word(a));
      f_cyc_q.push_back(gcyc + 2);
      n_f_exp++;
    end
    @(posedge clk); #1;
    fetch_req_i = 1'b0;
  endtask

  task automatic l_issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit exp_resp, output int gcyc);
    gcyc = -1;
    ld_req_i   = 1'b1;
    ld_we_i    = we;
    ld_addr_i  = a;
    ld_wdata_i = wd;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ld_gnt_o) begin gcyc = cyc; break; end
      @(posedge clk); #1;
    end
    if (gcyc < 0) chk("ld_gnt_timeout", 32'd0, 32'd1);
    else if (exp_resp) begin
      l_exp_q.push_back(exp_d);
      l_cyc_q.push_back(gcyc + 2);
    end
    @(posedge clk); #1;
    ld_req_i = 1'b0;
    ld_we_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g1, g2, ga, gb, cs, idx, fg0;

    // Requests asserted during reset must not leak to any output.
    fetch_req_i = 1'b1;
    ld_req_i    = 1'b1;
    #12;
    chk("reset_outputs_zero", 32'(|{fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, ld_gnt_o,
        ld_rvalid_o, ld_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
    fetch_req_i = 1'b0;
    ld_req_i    = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    idle(2);

    // Two fetches: grant c0, data at c2, next grant at c2.
    f_issue(32'h0, 1'b1, g1);
    f_issue(32'h4, 1'b1, g2);
    chk("fetch_back_to_back_spacing", 32'(g2 - g1), 32'd2);
    idle(4);

    // Starvation: fetch held, loader wins the fifth window.
    glog.delete();
    fork
      begin
        for (int i = 0; i < 5; i++) f_issue(32'h200 + 32'(4 * i), 1'b1, ga);
      end
      begin
        l_issue(1'b0, 32'h100, 32'd0, init_word(32'h100), 1'b1, gb);
        chk("starve_cnt_cleared", 32'(dut.starve_q), 32'd0);
      end
    join
    idx = -1;
    for (int i = 0; i < glog.size(); i++) if (glog[i] && idx < 0) idx = i;
    chk("starve_loader_grant_slot", 32'(idx), 32'd4);
    idle(4);

    // Loader write then read-back with fetch disabled but requesting.
    fetch_en_i  = 1'b0;
    fetch_req_i = 1'b1;
    fg0 = n_fgnt;
    l_issue(1'b1, 32'h40, 32'hDEAD_BEEF, 32'd0, 1'b1, ga);
    l_issue(1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF, 1'b1, gb);
    chk("loader_read_after_write_spacing", 32'(gb - ga), 32'd2);
    idle(3);
    chk("fetch_disabled_no_grant", 32'(n_fgnt - fg0), 32'd0);
    fetch_req_i = 1'b0;
    fetch_en_i  = 1'b1;
    idle(2);

    // Flush one cycle after grant suppresses the response.
    f_issue(32'h8, 1'b0, g1);
    fetch_flush_i = 1'b1;
    idle(1);
    fetch_flush_i = 1'b0;
    idle(3);
    // Flush inside a grant window blocks the grant.
    fetch_req_i   = 1'b1;
    fetch_addr_i  = 32'hC;
    fetch_flush_i = 1'b1;
    @(negedge clk);
    chk("flush_blocks_fetch_gnt", {31'd0, fetch_gnt_o}, 32'd0);
    chk("flush_blocks_mem_en", {31'd0, mem_en_o}, 32'd0);
    @(posedge clk); #1;
    fetch_flush_i = 1'b0;
    f_issue(32'hC, 1'b1, g1);
    idle(4);

    // Reset mid-BUSY: in-flight loader read is dropped.
    l_issue(1'b0, 32'h104, 32'd0, 32'd0, 1'b0, ga);
    fetch_req_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_busy_outputs_zero", 32'(|{fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, ld_gnt_o,
        ld_rvalid_o, ld_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
    @(posedge clk); #1;
    fetch_req_i = 1'b0;
    rst_n = 1'b1;
    idle(3);
    cs = cyc;
    f_issue(32'h10, 1'b1, g1);
    chk("grant_from_idle_after_reset", 32'(g1), 32'(cs));
    idle(4);

    // MEM_LAT=1: both held, grant every cycle, strictly alternating.
    f1_req  = 1'b1;
    l1_req  = 1'b1;
    f1_addr = 32'h1000;
    l1_addr = 32'h2000;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_one_grant_per_cycle", {31'd0, f1_gnt ^ l1_gnt}, 32'd1);
      if (i > 0) chk("alt_owner_toggles", {31'd0, l1_gnt}, 32'(idx == 0));
      if (l1_gnt) begin
        l1_exp_q.push_back(~l1_addr);
        l1_cyc_q.push_back(cyc + 1);
        idx = 1;
      end else begin
        f1_exp_q.push_back(~f1_addr);
        f1_cyc_q.push_back(cyc + 1);
        idx = 0;
      end
      @(posedge clk); #1;
      if (idx == 1) l1_addr = l1_addr + 32'd4;
      else f1_addr = f1_addr + 32'd4;
    end
    f1_req = 1'b0;
    l1_req = 1'b0;
    idle(6);

    chk("fetch_queue_drained", 32'(f_exp_q.size()), 32'd0);
    chk("ld_queue_drained", 32'(l_exp_q.size()), 32'd0);
    chk("alt_queues_drained", 32'(f1_exp_q.size() + l1_exp_q.size()), 32'd0);
    chk("fetch_rvalid_count", 32'(n_f_rv), 32'(n_f_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
